uart_tx_arbiter: RTL

Shares the single UART transmit serializer between two frame requesters: the debounced-button command path (requester 0) and the periodic status/echo path (requester 1). It sits between the requesters and the `tx` serializer. It grants one 8-bit frame at a time using round-robin priority, pulses the serializer's start, and waits for frame completion. A watchdog recovers if the serializer never reports done.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Request/grant and serializer handshake bundle shared by the two frame
// requesters, the UART tx serializer and the arbiter between them.
interface uart_tx_arbiter_if;
  logic       req0;
  logic [7:0] frame0;
  logic       gnt0;
  logic       req1;
  logic [7:0] frame1;
  logic       gnt1;
  logic       tx_start;
  logic [7:0] tx_frame;
  logic       tx_done;
  logic       busy;
  logic [7:0] sent_count;
  logic       err_timeout;

  // Requester/serializer side
  modport master (
    output req0, frame0, req1, frame1, tx_done,
    input  gnt0, gnt1, tx_start, tx_frame, busy, sent_count, err_timeout
  );

  // Arbiter side
  modport slave (
    input  req0, frame0, req1, frame1, tx_done,
    output gnt0, gnt1, tx_start, tx_frame, busy, sent_count, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx serializer between two frame
// requesters, with a done watchdog and an enforced inter-frame gap.
module uart_tx_arbiter #(
  parameter int TIMEOUT = 60000,
  parameter int GAP     = 2
) (
  input  logic             clock,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int WD_W     = 17;
  // SPACE always lasts at least one cycle, even when GAP is zero
  localparam int GAP_LAST = (GAP > 1) ? GAP - 1 : 0;

  typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_DONE, SPACE} state_t;

  state_t          state_reg, state_next;
  logic            last_reg, last_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic [3:0]      gap_reg, gap_next;
  logic [7:0]      frame_reg, frame_next;
  logic [7:0]      count_reg, count_next;
  logic            err_reg, err_next;
  logic            gnt0_reg, gnt0_next;
  logic            gnt1_reg, gnt1_next;
  logic            start_reg, start_next;
  logic            busy_reg, busy_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      wd_reg    <= '0;
      gap_reg   <= '0;
      frame_reg <= 8'h00;
      count_reg <= 8'h00;
      err_reg   <= 1'b0;
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      wd_reg    <= wd_next;
      gap_reg   <= gap_next;
      frame_reg <= frame_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      gnt0_reg  <= gnt0_next;
      gnt1_reg  <= gnt1_next;
      start_reg <= start_next;
      busy_reg  <= busy_next;
    end
  end

  // Outputs are registered, so pulses are decided on the transition into a state
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    wd_next    = wd_reg;
    gap_next   = gap_reg;
    frame_next = frame_reg;
    count_next = count_reg;
    err_next   = err_reg;
    gnt0_next  = 1'b0;
    gnt1_next  = 1'b0;
    start_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_reg)) begin
          frame_next = bus.frame0;
          last_next  = 1'b0;
          gnt0_next  = 1'b1;
          state_next = GRANT;
        end else if (bus.req1) begin
          frame_next = bus.frame1;
          last_next  = 1'b1;
          gnt1_next  = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        start_next = 1'b1;
        state_next = START;
      end
      START: begin
        wd_next    = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done on the final watchdog cycle still counts as a good frame
        if (bus.tx_done) begin
          count_next = count_reg + 8'd1;
          gap_next   = '0;
          state_next = SPACE;
        end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          gap_next   = '0;
          state_next = SPACE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      SPACE: begin
        if (gap_reg >= 4'(GAP_LAST)) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign bus.gnt0        = gnt0_reg;
  assign bus.gnt1        = gnt1_reg;
  assign bus.tx_start    = start_reg;
  assign bus.tx_frame    = frame_reg;
  assign bus.busy        = busy_reg;
  assign bus.sent_count  = count_reg;
  assign bus.err_timeout = err_reg;
endmodule
